// File: rtl/ps2_dir_ctrl.sv
// ps2_dir_ctrl
// Receives PS/2 keyboard frames (scan code set 2) and turns them into
// pac-man direction commands plus a pause toggle. Raw bytes and frame
// errors are also reported for debug LEDs.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | waiting for a start bit (data low at a sample point)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking parity and stop bit, publishing the byte
//
// Ports:
//   clk          in   system clock (50 MHz)
//   rst_n        in   asynchronous active-low reset
//   ps2_clk      in   PS/2 clock from keyboard (asynchronous)
//   ps2_data     in   PS/2 data from keyboard (asynchronous)
//   scan_code_o  out  last correctly received byte
//   scan_valid_o out  1-cycle pulse when scan_code_o updates
//   frame_err_o  out  1-cycle pulse on parity, stop-bit or timeout error
//   dir_o        out  direction: 00 up, 01 right, 10 down, 11 left
//   dir_valid_o  out  1-cycle pulse per direction make code (incl. typematic)
//   key_held_o   out  high while the last-pressed direction key is held
//   pause_o      out  toggles on each fresh Esc press
module ps2_dir_ctrl #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code_o,
  output logic       scan_valid_o,
  output logic       frame_err_o,
  output logic [1:0] dir_o,
  output logic       dir_valid_o,
  output logic       key_held_o,
  output logic       pause_o
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [1:0]      clk_sync, data_sync;
  logic            clk_s, data_s;
  logic            filt, filt_q;
  logic [FLT_W-1:0] flt_cnt;
  logic            sample;

  logic [1:0]      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;

  logic            brk, esc_down;
  logic [7:0]      held_code;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  // Falling edge of the filtered clock; data is taken in this same cycle.
  assign sample = filt_q & ~filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_q    <= filt;
      // Level flips only on the FILTER_LEN-th consecutive differing sample.
      if (clk_s != filt) begin
        if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
          filt    <= clk_s;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      scan_code_o  <= 8'h00;
      scan_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      scan_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (sample) begin
        // A sample point beats a coincident timeout.
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= data_s;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if ((^{shift, par_bit}) && data_s) begin
              scan_code_o  <= shift;
              scan_valid_o <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
            end
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state       <= ST_IDLE;
          frame_err_o <= 1'b1;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Arrow keys (E0-prefixed) and keypad keys share the same second byte,
  // so E0 carries no information here and is simply skipped without
  // disturbing a pending F0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_o       <= 2'b11;
      dir_valid_o <= 1'b0;
      key_held_o  <= 1'b0;
      pause_o     <= 1'b0;
      brk         <= 1'b0;
      esc_down    <= 1'b0;
      held_code   <= 8'h00;
    end else begin
      dir_valid_o <= 1'b0;
      if (scan_valid_o) begin
        case (scan_code_o)
          8'hE0: ;
          8'hF0: brk <= 1'b1;
          8'h75, 8'h74, 8'h72, 8'h6B: begin
            brk <= 1'b0;
            if (!brk) begin
              case (scan_code_o)
                8'h75:   dir_o <= 2'b00;
                8'h74:   dir_o <= 2'b01;
                8'h72:   dir_o <= 2'b10;
                default: dir_o <= 2'b11;
              endcase
              dir_valid_o <= 1'b1;
              key_held_o  <= 1'b1;
              held_code   <= scan_code_o;
            end else if (scan_code_o == held_code) begin
              key_held_o <= 1'b0;
            end
          end
          8'h76: begin
            brk <= 1'b0;
            if (brk) begin
              esc_down <= 1'b0;
            end else if (!esc_down) begin
              pause_o  <= ~pause_o;
              esc_down <= 1'b1;
            end
          end
          default: brk <= 1'b0;
        endcase
      end
    end
  end

endmodule
